red_pitaya_xfade_bypass: RTL and testbench
==========================================

Name: red_pitaya_xfade_bypass

Overview:
Multi-channel, click-free successor of the single-channel hard bypass. Each channel crossfades between its dry input and its wet (effect) input with a linear gain ramp, so enable/disable produces no audible pop. Control and status are held in registers on the system bus. The block sits between the ADC-side signal path and the effect output stage.

Parameters:
CH, 2, number of channels (1..8)
DW, 14, signed sample width per channel
GW, 15, unsigned gain width; unity gain ONE = 2^(GW-1)
PW, 16, ramp prescaler width

Ports:
clk_i  in  1  single clock for the datapath and the bus
rstn_i  in  1  reset, asynchronous and active-low; also used by the bus logic
dry_i  in  CH*DW  packed signed dry samples, channel 0 in the LSBs
wet_i  in  CH*DW  packed signed wet samples
sig_o  out  CH*DW  packed signed crossfaded output
sys_addr_i  in  32  bus address; only [7:0] is decoded
sys_wdata_i  in  32  bus write data
sys_sel_i  in  4  byte select; ignored, full-word access only
sys_wen_i  in  1  write strobe, one cycle
sys_ren_i  in  1  read strobe, one cycle
sys_rdata_o  out  32  read data
sys_err_o  out  1  error indication
sys_ack_o  out  1  acknowledge

Behaviour:
- Reset (async assert, sync release): all registers and outputs zero, except RAMP_STEP = 1 and RAMP_DIV = 0. All gains g[c] = 0, so the output is fully dry.
- Register map (byte addresses):
  - 0x00 ENABLE, R/W, bits [CH-1:0]; target[c] = ENABLE[c] ? ONE : 0.
  - 0x04 RAMP_STEP, R/W, bits [GW-1:0].
  - 0x08 RAMP_DIV, R/W, bits [PW-1:0].
  - 0x0C STATUS, RO, bits [CH-1:0] = ramping[c], i.e. g[c] != target[c].
  - 0x10 ID, RO, 0x58460000 | (CH<<8) | DW.
  - Unused register bits read 0.
- Bus handshake:
  - sys_ack_o pulses high exactly one cycle after every wen or ren.
  - sys_rdata_o is valid in the ack cycle.
  - Unmapped address, or a write to an RO register: ack and sys_err_o pulse together; a write has no effect.
  - wen and ren asserted in the same cycle: the write wins, and a single ack is issued.
- Prescaler: pcnt counts 0..RAMP_DIV. tick = (pcnt == RAMP_DIV), then pcnt wraps to 0. RAMP_DIV = 0 gives a tick every cycle. Writing RAMP_DIV clears pcnt.
- Ramp, per channel, evaluated on tick only:
  - g < target: g = min(g + RAMP_STEP, target).
  - g > target: g = max(g - RAMP_STEP, target).
  - Compute in GW+1 bits so the result saturates and never wraps.
  - RAMP_STEP = 0: g jumps to target on the next tick.
- ENABLE changed mid-ramp: the ramp reverses from the current g. g never resets and never jumps.
- Datapath, 2-cycle latency, fully pipelined with no stalls:
  - Stage 1 registers pw = wet*g and pd = dry*(ONE-g), each signed DW+GW bits, using the gain sampled in the same cycle.
  - Stage 2 registers sig_o = (pw + pd) >>> (GW-1), an arithmetic shift that truncates toward -inf.
  - The result is a convex combination, so no overflow is possible. The sum is held at DW+GW+1 bits, then sliced to DW.
- g = ONE gives sig_o = wet exactly. g = 0 gives sig_o = dry exactly.
- Reset mid-ramp: g returns to 0 and sig_o to 0 immediately. The first valid output arrives 2 cycles after reset release.

Decomposition:
- Package red_pitaya_xfade_pkg holds:
  - register address constants ADDR_ENABLE, ADDR_STEP, ADDR_DIV, ADDR_STATUS, ADDR_ID;
  - the ID constant;
  - the ONE-computation function.
- Sub-module xfade_gain_ramp holds one channel's g register and its min/max stepping. It has inputs tick, target, step and outputs g, ramping. The top level instantiates CH copies in a generate loop and keeps the shared bus, prescaler and multiply pipeline.

Test Plan:
- Reset: set CH=2, dry=+1000/-1000, wet=+3000/-3000, no writes -> sig_o = +1000/-1000 after 2 cycles; a read of 0x10 returns 0x5846020E with ack one cycle after ren.
- Step 0: RAMP_STEP=0, write ENABLE=0x1 -> on the next tick g0 = 16384, and two cycles later ch0 = +3000 while ch1 stays -1000.
- Linear ramp: RAMP_STEP=4096, RAMP_DIV=3, ENABLE=0x1, dry=0, wet=8000:
  - ch0 steps through 2000, 4000, 6000, 8000, every 4 cycles;
  - STATUS bit0 is 1 during the ramp and 0 after it completes.
- Reversal: start the ramp above, write ENABLE=0 when g = 8192 -> g steps 4096 then 0; no value exceeds 4000; no jump.
- Saturation: RAMP_STEP=10000, enable -> g goes 10000 then 16384, never exceeding ONE; ch0 equals wet exactly, including wet = -8192 and +8191.
- Bus errors: read 0x20 -> ack=1, err=1, rdata=0; write 0x0C -> ack=1, err=1, STATUS unchanged; simultaneous wen/ren to 0x00 -> a single ack and the write applied.

Source files
------------

// File: rtl/red_pitaya_xfade_pkg.sv
// -----------------------------------------------------------------------------
// red_pitaya_xfade_pkg
//
// Shared constants and helpers for the multi-channel crossfading bypass.
//   - Byte addresses of the control/status registers on the system bus.
//   - Fixed upper half of the ID register and a helper that builds the full ID.
//   - Helper that computes unity gain (ONE) for a given gain width.
// -----------------------------------------------------------------------------
package red_pitaya_xfade_pkg;

   // Register byte addresses (only sys_addr_i[7:0] is decoded).
   localparam logic [7:0] ADDR_ENABLE = 8'h00;
   localparam logic [7:0] ADDR_STEP   = 8'h04;
   localparam logic [7:0] ADDR_DIV    = 8'h08;
   localparam logic [7:0] ADDR_STATUS = 8'h0C;
   localparam logic [7:0] ADDR_ID     = 8'h10;

   // "XF" signature in the upper half of the ID register.
   localparam logic [31:0] ID_BASE = 32'h5846_0000;

   // Full ID word: signature, channel count in [15:8], sample width in [7:0].
   function automatic logic [31:0] xfade_id(input int ch, input int dw);
      return ID_BASE | (32'(ch) << 8) | 32'(dw);
   endfunction

   // Unity gain for an unsigned gain of width gw: 2^(gw-1).
   function automatic int unsigned gain_one(input int gw);
      return 32'd1 << (gw - 1);
   endfunction

endpackage

// File: rtl/red_pitaya_xfade_gain_ramp.sv
// -----------------------------------------------------------------------------
// xfade_gain_ramp
//
// One channel's gain register. On every prescaler tick the gain moves towards
// its target by 'step', clamping at the target so it never overshoots. A step
// of zero makes the gain jump straight to the target on the next tick. The
// target may change at any time; the ramp simply continues from the current
// gain in the new direction.
//
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset (gain returns to 0)
//   tick     ramp enable strobe from the shared prescaler
//   target   gain the channel is heading for (0 or ONE)
//   step     gain increment per tick
//   g        current gain
//   ramping  high while g differs from target
// -----------------------------------------------------------------------------
module xfade_gain_ramp #(
   parameter int GW = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tick,
   input  logic [GW-1:0] target,
   input  logic [GW-1:0] step,
   output logic [GW-1:0] g,
   output logic          ramping
);

   // One extra bit so the sum cannot wrap and the difference can go negative;
   // the clamp against target then stays a plain comparison.
   logic        [GW:0]   up_sum;
   logic signed [GW:0]   down_diff;
   logic        [GW-1:0] g_next;

   assign up_sum    = {1'b0, g} + {1'b0, step};
   assign down_diff = $signed({1'b0, g}) - $signed({1'b0, step});

   always_comb begin
      // NOTE: default assignment first keeps this purely combinational (no latch).
      g_next = g;
      if (step == '0) begin
         g_next = target;
      end else if (g < target) begin
         g_next = (up_sum >= {1'b0, target}) ? target : up_sum[GW-1:0];
      end else if (g > target) begin
         g_next = (down_diff <= $signed({1'b0, target})) ? target : down_diff[GW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst_n) begin
         g <= '0;
      end else if (tick) begin
         g <= g_next;
      end
   end

   assign ramping = (g != target);

endmodule

// File: rtl/red_pitaya_xfade_bypass.sv
// -----------------------------------------------------------------------------
// red_pitaya_xfade_bypass
//
// Multi-channel click-free bypass. Each channel crossfades between its dry
// input and its wet (effect) input with a linearly ramped gain g:
//    sig = (wet*g + dry*(ONE-g)) >>> (GW-1)
// Enabling a channel ramps g up to ONE (fully wet); disabling ramps it back to
// 0 (fully dry). Ramp speed is set by RAMP_STEP (gain per tick) and RAMP_DIV
// (a tick every RAMP_DIV+1 cycles).
//
// Register map (byte addresses, full-word access):
//   0x00 ENABLE     R/W  [CH-1:0] per-channel wet enable
//   0x04 RAMP_STEP  R/W  [GW-1:0] gain step per tick (reset 1)
//   0x08 RAMP_DIV   R/W  [PW-1:0] prescaler divide (reset 0)
//   0x0C STATUS     RO   [CH-1:0] channel still ramping
//   0x10 ID         RO   0x5846_0000 | CH<<8 | DW
//
// Ports:
//   clk_i        clock for datapath and bus
//   rstn_i       asynchronous active-low reset
//   dry_i        packed signed dry samples, channel 0 in the LSBs
//   wet_i        packed signed wet samples
//   sig_o        packed signed crossfaded output, 2-cycle latency
//   sys_addr_i   bus address, [7:0] decoded
//   sys_wdata_i  bus write data
//   sys_sel_i    byte select, ignored
//   sys_wen_i    write strobe
//   sys_ren_i    read strobe
//   sys_rdata_o  read data, valid with ack
//   sys_err_o    error (unmapped address or write to read-only register)
//   sys_ack_o    acknowledge, one cycle after each access
// -----------------------------------------------------------------------------
module red_pitaya_xfade_bypass
   import red_pitaya_xfade_pkg::*;
#(
   parameter int CH = 2,
   parameter int DW = 14,
   parameter int GW = 15,
   parameter int PW = 16
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic [CH*DW-1:0] dry_i,
   input  logic [CH*DW-1:0] wet_i,
   output logic [CH*DW-1:0] sig_o,
   input  logic [31:0]      sys_addr_i,
   input  logic [31:0]      sys_wdata_i,
   input  logic [3:0]       sys_sel_i,
   input  logic             sys_wen_i,
   input  logic             sys_ren_i,
   output logic [31:0]      sys_rdata_o,
   output logic             sys_err_o,
   output logic             sys_ack_o
);

   localparam logic [GW-1:0] ONE    = GW'(gain_one(GW));
   localparam logic [31:0]   ID_VAL = xfade_id(CH, DW);
   localparam int            PRW    = DW + GW;   // product width
   localparam int            SW     = PRW + 1;   // sum width

   // --------------------------------------------------------------------------
   // Control registers
   // --------------------------------------------------------------------------
   logic [CH-1:0] enable_q;
   logic [GW-1:0] step_q;
   logic [PW-1:0] div_q;
   logic [CH-1:0] ramping;

   logic [7:0]    addr;
   logic          rd_ok;
   logic          wr_ok;
   logic [31:0]   rd_mux;
   logic          wr_en;

   // Byte enables and upper address bits carry no meaning for this block.
   logic unused_bus;
   assign unused_bus = ^{sys_addr_i[31:8], sys_sel_i};

   assign addr = sys_addr_i[7:0];

   // Address decode: readable set, writable subset, and read data.
   always_comb begin
      rd_mux = '0;
      rd_ok  = 1'b1;
      wr_ok  = 1'b0;
      case (addr)
         ADDR_ENABLE: begin
            rd_mux = 32'(enable_q);
            wr_ok  = 1'b1;
         end
         ADDR_STEP: begin
            rd_mux = 32'(step_q);
            wr_ok  = 1'b1;
         end
         ADDR_DIV: begin
            rd_mux = 32'(div_q);
            wr_ok  = 1'b1;
         end
         ADDR_STATUS: rd_mux = 32'(ramping);
         ADDR_ID:     rd_mux = ID_VAL;
         default:     rd_ok  = 1'b0;
      endcase
   end

   // A valid write; an invalid one is acknowledged with error and dropped.
   assign wr_en = sys_wen_i && wr_ok;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         enable_q <= '0;
         step_q   <= GW'(1);
         div_q    <= '0;
      end else if (wr_en) begin
         case (addr)
            ADDR_ENABLE: enable_q <= sys_wdata_i[CH-1:0];
            ADDR_STEP:   step_q   <= sys_wdata_i[GW-1:0];
            ADDR_DIV:    div_q    <= sys_wdata_i[PW-1:0];
            default:     ;
         endcase
      end
   end

   // Bus response: one ack per access cycle. When wen and ren coincide the
   // access is handled purely as a write, so no read data is returned.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sys_ack_o   <= 1'b0;
         sys_err_o   <= 1'b0;
         sys_rdata_o <= '0;
      end else begin
         sys_ack_o   <= sys_wen_i || sys_ren_i;
         sys_err_o   <= sys_wen_i ? !wr_ok : (sys_ren_i && !rd_ok);
         sys_rdata_o <= (sys_ren_i && !sys_wen_i && rd_ok) ? rd_mux : '0;
      end
   end

   // --------------------------------------------------------------------------
   // Ramp prescaler: tick once every div_q+1 cycles. A write to RAMP_DIV
   // restarts the count so the new period starts cleanly.
   // --------------------------------------------------------------------------
   logic [PW-1:0] pcnt;
   logic          tick;

   assign tick = (pcnt == div_q);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pcnt <= '0;
      end else if (wr_en && (addr == ADDR_DIV)) begin
         pcnt <= '0;
      end else if (tick) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + PW'(1);
      end
   end

   // --------------------------------------------------------------------------
   // Per-channel gain ramp and two-stage multiply/sum pipeline
   // --------------------------------------------------------------------------
   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic        [GW-1:0] g;
      logic        [GW-1:0] tgt;
      logic signed [PRW-1:0] wet_x;
      logic signed [PRW-1:0] dry_x;
      logic signed [PRW-1:0] g_x;
      logic signed [PRW-1:0] h_x;
      logic signed [PRW-1:0] pw;
      logic signed [PRW-1:0] pd;
      logic signed [SW-1:0]  sum;
      logic signed [DW-1:0]  sig_q;

      assign tgt = enable_q[c] ? ONE : '0;

      xfade_gain_ramp #(
         .GW(GW)
      ) u_ramp (
         .clk     (clk_i),
         .rst_n   (rstn_i),
         .tick    (tick),
         .target  (tgt),
         .step    (step_q),
         .g       (g),
         .ramping (ramping[c])
      );

      // Operands widened to the product width so the multiply is exact:
      // samples sign-extended, gains (always 0..ONE) zero-extended.
      assign wet_x = {{GW{wet_i[c*DW+DW-1]}}, wet_i[c*DW +: DW]};
      assign dry_x = {{GW{dry_i[c*DW+DW-1]}}, dry_i[c*DW +: DW]};
      assign g_x   = {{DW{1'b0}}, g};
      assign h_x   = {{DW{1'b0}}, ONE - g};

      // Convex combination: |sum| <= 2^(DW-1) * ONE, so no overflow.
      assign sum = {pw[PRW-1], pw} + {pd[PRW-1], pd};

      always_ff @(posedge clk_i or negedge rstn_i) begin
         // NOTE: pipeline registers are reset too, so sig_o reads 0 in reset.
         if (!rstn_i) begin
            pw    <= '0;
            pd    <= '0;
            sig_q <= '0;
         end else begin
            pw    <= wet_x * g_x;
            pd    <= dry_x * h_x;
            // Arithmetic shift floors toward -inf; the slice cannot lose
            // significant bits because the result lies between dry and wet.
            sig_q <= DW'(sum >>> (GW - 1));
         end
      end

      assign sig_o[c*DW +: DW] = sig_q;
   end

endmodule

// File: tb/tb_red_pitaya_xfade_bypass.sv
// -----------------------------------------------------------------------------
// tb_red_pitaya_xfade_bypass
//
// Directed bench for the crossfading bypass (CH=2, DW=14, GW=15, PW=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_red_pitaya_xfade_bypass;

   localparam int CH = 2;
   localparam int DW = 14;
   localparam int GW = 15;
   localparam int PW = 16;

   localparam logic [31:0] A_ENABLE = 32'h00;
   localparam logic [31:0] A_STEP   = 32'h04;
   localparam logic [31:0] A_DIV    = 32'h08;
   localparam logic [31:0] A_STATUS = 32'h0C;
   localparam logic [31:0] A_ID     = 32'h10;
   localparam logic [31:0] ID_EXP   = 32'h5846_020E;

   logic             clk = 1'b0;
   logic             rstn;
   logic [CH*DW-1:0] dry;
   logic [CH*DW-1:0] wet;
   logic [CH*DW-1:0] sig;
   logic [31:0]      addr;
   logic [31:0]      wdata;
   logic [3:0]       sel;
   logic             wen;
   logic             ren;
   logic [31:0]      rdata;
   logic             err;
   logic             ack;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   red_pitaya_xfade_bypass #(
      .CH(CH), .DW(DW), .GW(GW), .PW(PW)
   ) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .dry_i       (dry),
      .wet_i       (wet),
      .sig_o       (sig),
      .sys_addr_i  (addr),
      .sys_wdata_i (wdata),
      .sys_sel_i   (sel),
      .sys_wen_i   (wen),
      .sys_ren_i   (ren),
      .sys_rdata_o (rdata),
      .sys_err_o   (err),
      .sys_ack_o   (ack)
   );

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic signed [31:0] ch_out(input int c);
      logic [DW-1:0] v;
      v = sig[c*DW +: DW];
      return {{(32-DW){v[DW-1]}}, v};
   endfunction

   task automatic set_in(input int d0, input int d1, input int w0, input int w1);
      dry = {DW'(d1), DW'(d0)};
      wet = {DW'(w1), DW'(w0)};
   endtask

   // Called on a falling edge; returns on the following falling edge.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                            input logic exp_err);
      addr  = a;
      wdata = d;
      wen   = 1'b1;
      @(negedge clk);
      wen = 1'b0;
      check("wr_ack", ack, 1);
      check("wr_err", err, exp_err);
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [31:0] exp_data,
                           input logic exp_err);
      addr = a;
      ren  = 1'b1;
      @(negedge clk);
      ren = 1'b0;
      check("rd_ack", ack, 1);
      check("rd_err", err, exp_err);
      check("rd_data", rdata, exp_data);
   endtask

   initial begin
      rstn  = 1'b0;
      wen   = 1'b0;
      ren   = 1'b0;
      addr  = '0;
      wdata = '0;
      sel   = 4'hF;
      set_in(1000, -1000, 3000, -3000);

      // ---- Reset state and first-output latency ----
      #12;
      check("rst_sig0", ch_out(0), 0);
      check("rst_sig1", ch_out(1), 0);
      check("rst_ack", ack, 0);
      check("rst_err", err, 0);
      check("rst_rdata", rdata, 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("lat1_sig0", ch_out(0), 0);
      @(negedge clk);
      check("dry_sig0", ch_out(0), 1000);
      check("dry_sig1", ch_out(1), -1000);
      bus_read(A_ID, ID_EXP, 1'b0);
      @(negedge clk);
      check("ack_single", ack, 0);
      bus_read(A_STEP, 1, 1'b0);
      bus_read(A_DIV, 0, 1'b0);
      bus_read(A_ENABLE, 0, 1'b0);

      // ---- Step 0: jump to wet on the next tick ----
      bus_write(A_STEP, 0, 1'b0);
      bus_write(A_ENABLE, 1, 1'b0);
      for (int n = 1; n <= 3; n++) begin
         @(negedge clk);
         check("step0_sig0", ch_out(0), (n < 3) ? 1000 : 3000);
      end
      check("step0_sig1", ch_out(1), -1000);
      bus_write(A_ENABLE, 0, 1'b0);
      repeat (4) @(negedge clk);
      check("step0_back", ch_out(0), 1000);

      // ---- Linear ramp: 2000, 4000, 6000, 8000 every 4 cycles ----
      set_in(0, 0, 8000, 8000);
      bus_write(A_STEP, 4096, 1'b0);
      bus_write(A_DIV, 3, 1'b0);
      bus_write(A_ENABLE, 1, 1'b0);
      for (int n = 2; n <= 21; n++) begin
         int e;
         @(negedge clk);
         e = (n < 6) ? 0 : ((n - 2) / 4) * 2000;
         if (e > 8000) e = 8000;
         check("lin_sig0", ch_out(0), e);
      end
      check("lin_sig1", ch_out(1), 0);
      bus_read(A_STATUS, 0, 1'b0);
      bus_write(A_ENABLE, 0, 1'b0);
      repeat (20) @(negedge clk);
      check("lin_down", ch_out(0), 0);

      // ---- Reversal at g = 8192 ----
      bus_write(A_DIV, 3, 1'b0);
      bus_write(A_ENABLE, 1, 1'b0);
      bus_read(A_STATUS, 1, 1'b0);
      repeat (6) @(negedge clk);
      bus_write(A_ENABLE, 0, 1'b0);
      check("rev_start", ch_out(0), 2000);
      for (int n = 10; n <= 21; n++) begin
         @(negedge clk);
         check("rev_sig0", ch_out(0), (n < 14) ? 4000 : (n < 18) ? 2000 : 0);
      end

      // ---- Saturation: g 10000 then ONE ----
      bus_write(A_DIV, 0, 1'b0);
      bus_write(A_STEP, 10000, 1'b0);
      bus_write(A_ENABLE, 1, 1'b0);
      for (int n = 3; n <= 8; n++) begin
         @(negedge clk);
         check("sat_sig0", ch_out(0), (n < 5) ? 0 : (n == 5) ? 4882 : 8000);
      end
      set_in(8191, -8192, -8192, 100);
      repeat (2) @(negedge clk);
      check("wet_min", ch_out(0), -8192);
      check("dry_min", ch_out(1), -8192);
      set_in(-8192, 8191, 8191, 0);
      repeat (2) @(negedge clk);
      check("wet_max", ch_out(0), 8191);
      check("dry_max", ch_out(1), 8191);

      // ---- Bus errors and write/read collision ----
      bus_read(32'h20, 0, 1'b1);
      bus_write(A_STATUS, 32'hFF, 1'b1);
      bus_read(A_STATUS, 0, 1'b0);
      bus_write(A_ID, 0, 1'b1);
      bus_read(A_ID, ID_EXP, 1'b0);
      addr  = A_ENABLE;
      wdata = 32'h2;
      wen   = 1'b1;
      ren   = 1'b1;
      @(negedge clk);
      wen = 1'b0;
      ren = 1'b0;
      check("both_ack", ack, 1);
      check("both_err", err, 0);
      @(negedge clk);
      check("both_single", ack, 0);
      bus_read(A_ENABLE, 2, 1'b0);
      bus_write(A_STEP, 32'hFFFF_FFFF, 1'b0);
      bus_read(A_STEP, 32'h7FFF, 1'b0);
      bus_write(A_ENABLE, 32'hFFFF_FFFF, 1'b0);
      bus_read(A_ENABLE, 3, 1'b0);

      // ---- Reset in the middle of a ramp ----
      set_in(1000, -1000, 3000, -3000);
      bus_write(A_STEP, 4096, 1'b0);
      bus_write(A_DIV, 3, 1'b0);
      bus_write(A_ENABLE, 0, 1'b0);
      repeat (6) @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check("mid_rst_sig0", ch_out(0), 0);
      check("mid_rst_sig1", ch_out(1), 0);
      check("mid_rst_ack", ack, 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("rel_lat1", ch_out(0), 0);
      @(negedge clk);
      check("rel_sig0", ch_out(0), 1000);
      check("rel_sig1", ch_out(1), -1000);
      bus_read(A_STEP, 1, 1'b0);
      bus_read(A_STATUS, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
